fetch_stage: RTL and testbench

- Instruction-fetch stage upstream of the instruction decoder/controller.
- Owns the PC register and runs a request/acknowledge handshake with instruction memory.
- Holds the fetched word stable on `instruction` until the datapath signals completion.
- Computes the next PC from the decoder's one-hot jump type, the ALU zero flag and the rs register value.

---
 rtl/mips_fetch_pkg.sv | 24 ++
 rtl/npc_calc.sv | 39 +++
 rtl/fetch_stage.sv | 86 ++++++++
 tb/tb_fetch_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared constants and types for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

    localparam int          ADDR_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    localparam logic [4:0] JT_J   = 5'b00001;
    localparam logic [4:0] JT_JR  = 5'b00010;
    localparam logic [4:0] JT_BNE = 5'b00100;
    localparam logic [4:0] JT_BEQ = 5'b01000;
    localparam logic [4:0] JT_SEQ = 5'b10000;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection and jr alignment check.
module npc_calc
    import mips_fetch_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [25:0]       target_field,
    input  logic [4:0]        jump_type,
    input  logic              alu_zero,
    input  logic [31:0]       rs_data,
    output logic [ADDR_W-1:0] next_pc,
    output logic              align_err
);

    logic [ADDR_W-1:0] branch_target;

    assign branch_target = pc_plus4 + branch_offset(target_field[15:0]);

    always_comb begin
        next_pc   = pc_plus4;
        align_err = 1'b0;
        case (jump_type)
            JT_J:   next_pc = {pc_plus4[31:28], target_field, 2'b00};
            JT_JR: begin
                // a misaligned jr leaves pc where it is so the faulting address stays visible
                if (rs_data[1:0] != 2'b00) begin
                    align_err = 1'b1;
                    next_pc   = pc;
                end else begin
                    next_pc = rs_data;
                end
            end
            JT_BNE: if (!alu_zero) next_pc = branch_target;
            JT_BEQ: if (alu_zero)  next_pc = branch_target;
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem request/ack handshake, held instruction.
//   state | meaning
//   IDLE  | one cycle after reset release
//   FETCH | imem_req high at pc, waiting for imem_ack
//   ISSUE | instruction held and valid, waiting for exec_done
//   HALT  | misaligned jr target seen; only reset leaves
module fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instruction,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic [4:0]        jump_type,
    input  logic              alu_zero,
    input  logic [31:0]       rs_data,
    input  logic              exec_done,
    output logic              addr_err
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_FETCH = FETCH;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_HALT  = HALT;

    logic [1:0]        state;
    logic [ADDR_W-1:0] next_pc;
    logic              align_err;

    assign pc_plus4 = pc + 32'd4;

    npc_calc u_npc_calc (
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .target_field (instruction[25:0]),
        .jump_type    (jump_type),
        .alu_zero     (alu_zero),
        .rs_data      (rs_data),
        .next_pc      (next_pc),
        .align_err    (align_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            instruction <= 32'h0000_0000;
        end else begin
            case (state)
                ST_IDLE: state <= ST_FETCH;
                ST_FETCH: begin
                    if (imem_ack) begin
                        instruction <= imem_rdata;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (exec_done) begin
                        if (align_err) begin
                            state <= ST_HALT;
                        end else begin
                            pc    <= next_pc;
                            state <= ST_FETCH;
                        end
                    end
                end
                default: state <= state;
            endcase
        end
    end

    // decoded straight from state so reset drops the request without waiting for a clock
    assign imem_req   = (state == ST_FETCH);
    assign imem_addr  = pc;
    assign inst_valid = (state == ST_ISSUE);
    assign addr_err   = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected fetch addresses are queued at exec_done.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_b;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [4:0]  jump_type;
    logic        alu_zero;
    logic [31:0] rs_data;
    logic        exec_done;

    logic        imem_req, inst_valid, addr_err;
    logic [31:0] imem_addr, instruction, pc, pc_plus4;
    logic        imem_req_b, inst_valid_b, addr_err_b;
    logic [31:0] imem_addr_b, instruction_b, pc_b, pc_plus4_b;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
        .inst_valid(inst_valid), .pc(pc), .pc_plus4(pc_plus4), .jump_type(jump_type),
        .alu_zero(alu_zero), .rs_data(rs_data), .exec_done(exec_done), .addr_err(addr_err)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst(rst_b), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction_b),
        .inst_valid(inst_valid_b), .pc(pc_b), .pc_plus4(pc_plus4_b), .jump_type(jump_type),
        .alu_zero(alu_zero), .rs_data(rs_data), .exec_done(exec_done), .addr_err(addr_err_b)
    );

    // Waits for the request, pops the expected address, stalls, then acks with rdata.
    task automatic do_fetch(input int delay, input logic [31:0] rdata);
        bit          seen;
        logic [31:0] exp_addr;
        logic [31:0] held_addr;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (imem_req) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL req_timeout imem_req got %b exp 1", imem_req);
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty imem_addr got %h exp <queued>", imem_addr);
            exp_addr = 32'hx;
        end else begin
            exp_addr = exp_q.pop_front();
            if (imem_addr !== exp_addr) begin
                errors++;
                $display("FAIL fetch_addr got %h exp %h", imem_addr, exp_addr);
            end
        end
        held_addr = imem_addr;
        for (int i = 0; i < delay; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== held_addr || inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_stable req/addr/valid got %b/%h/%b exp 1/%h/0",
                         imem_req, imem_addr, inst_valid, held_addr);
            end
            @(negedge clk);
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        @(posedge clk);
        #1 imem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (instruction !== rdata || inst_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL capture instr/valid/req got %h/%b/%b exp %h/1/0",
                     instruction, inst_valid, imem_req, rdata);
        end
    endtask

    task automatic do_exec(input logic [4:0] jt, input logic zero, input logic [31:0] rs,
                           input bit push, input logic [31:0] exp_next);
        jump_type = jt;
        alu_zero  = zero;
        rs_data   = rs;
        exec_done = 1'b1;
        if (push) exp_q.push_back(exp_next);
        @(posedge clk);
        #1 exec_done = 1'b0;
        jump_type = 5'b10000;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || addr_err !== 1'b0 ||
            pc !== 32'h0040_0000 || instruction !== 32'h0 || pc_plus4 !== 32'h0040_0004) begin
            errors++;
            $display("FAIL reset req/valid/err/pc/instr/pc4 got %b/%b/%b/%h/%h/%h exp 0/0/0/00400000/00000000/00400004",
                     imem_req, inst_valid, addr_err, pc, instruction, pc_plus4);
        end
        rst = 1'b0;
        exp_q.push_back(32'h0040_0000);
    endtask

    task automatic test_first_fetch;
        do_fetch(0, 32'h2008_0005);
        checks++;
        if (pc_plus4 !== 32'h0040_0004) begin
            errors++;
            $display("FAIL first_pc_plus4 got %h exp 00400004", pc_plus4);
        end
    endtask

    task automatic test_delayed_ack;
        do_exec(5'b10000, 1'b0, 32'h0, 1'b1, 32'h0040_0004);
        do_fetch(3, 32'h0000_0020);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 imem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (instruction !== 32'h0000_0020 || inst_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL spurious_ack instr/valid/req got %h/%b/%b exp 00000020/1/0",
                     instruction, inst_valid, imem_req);
        end
        do_exec(5'b10000, 1'b0, 32'h0, 1'b1, 32'h0040_0008);
    endtask

    task automatic test_branches;
        do_fetch(0, 32'h1000_FFFF);
        do_exec(5'b01000, 1'b1, 32'h0, 1'b1, 32'h0040_0008);
        do_fetch(0, 32'h1000_FFFF);
        do_exec(5'b00100, 1'b1, 32'h0, 1'b1, 32'h0040_000C);
        do_fetch(1, 32'h0000_0000);
        do_exec(5'b10000, 1'b0, 32'h0, 1'b1, 32'h0040_0010);
    endtask

    task automatic test_jumps;
        do_fetch(0, 32'h0810_0000);
        do_exec(5'b00001, 1'b0, 32'h0, 1'b1, 32'h0040_0000);
        do_fetch(0, 32'h0000_0008);
        do_exec(5'b00010, 1'b0, 32'h0040_0020, 1'b1, 32'h0040_0020);
        do_fetch(2, 32'h1400_0003);
        do_exec(5'b00100, 1'b0, 32'h0, 1'b1, 32'h0040_0030);
        do_fetch(0, 32'h0000_0000);
        do_exec(5'b00011, 1'b1, 32'h0040_0080, 1'b1, 32'h0040_0034);
        do_fetch(0, 32'h0000_0000);
        do_exec(5'b00000, 1'b1, 32'h0040_0080, 1'b1, 32'h0040_0038);
    endtask

    task automatic test_jr_halt;
        do_fetch(0, 32'h0320_0008);
        do_exec(5'b00010, 1'b0, 32'h0040_0022, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (addr_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h0040_0038) begin
                errors++;
                $display("FAIL halt err/req/valid/pc got %b/%b/%b/%h exp 1/0/0/00400038",
                         addr_err, imem_req, inst_valid, pc);
            end
            imem_ack  = 1'b1;
            exec_done = 1'b1;
            jump_type = 5'b10000;
        end
        @(posedge clk);
        #1;
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
        end
    endtask

    task automatic test_wrap_and_async_reset;
        bit seen;
        @(negedge clk);
        checks++;
        if (pc_b !== 32'hFFFF_FFFC || pc_plus4_b !== 32'h0000_0000 || imem_req_b !== 1'b0) begin
            errors++;
            $display("FAIL wrap_reset pc/pc4/req got %h/%h/%b exp fffffffc/00000000/0",
                     pc_b, pc_plus4_b, imem_req_b);
        end
        rst_b = 1'b0;
        exp_q.push_back(32'hFFFF_FFFC);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (imem_req_b) seen = 1'b1;
        end
        checks++;
        if (!seen || exp_q.size() == 0) begin
            errors++;
            $display("FAIL wrap_req_timeout req got %b exp 1", imem_req_b);
        end else if (imem_addr_b !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL wrap_fetch_addr got %h exp fffffffc", imem_addr_b);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0000;
        @(posedge clk);
        #1 imem_ack = 1'b0;
        exp_q.push_back(32'h0000_0000);
        jump_type = 5'b10000;
        exec_done = 1'b1;
        @(posedge clk);
        #1 exec_done = 1'b0;
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wrap_scoreboard_empty addr got %h", imem_addr_b);
        end else if (imem_req_b !== 1'b1 || imem_addr_b !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL wrap_next req/addr got %b/%h exp 1/00000000", imem_req_b, imem_addr_b);
        end
        @(posedge clk);
        #2 rst_b = 1'b1;
        #1;
        checks++;
        if (imem_req_b !== 1'b0 || pc_b !== 32'hFFFF_FFFC || inst_valid_b !== 1'b0) begin
            errors++;
            $display("FAIL async_reset req/pc/valid got %b/%h/%b exp 0/fffffffc/0",
                     imem_req_b, pc_b, inst_valid_b);
        end
    endtask

    initial begin
        rst        = 1'b1;
        rst_b      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        jump_type  = 5'b10000;
        alu_zero   = 1'b0;
        rs_data    = 32'h0;
        exec_done  = 1'b0;
        test_reset;
        test_first_fetch;
        test_delayed_ack;
        test_branches;
        test_jumps;
        test_jr_halt;
        test_wrap_and_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
